// File: rtl/accel_ahb_regs_pkg.sv
// ---------------------------------------------------------------------------
// accel_regs_pkg : register map, bit positions and control states shared by
//                  the accelerator register bank.              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package accel_regs_pkg;

   localparam int unsigned OFF_CTRL          = 32'h00;
   localparam int unsigned OFF_STATUS        = 32'h04;
   localparam int unsigned OFF_ACCEL_X       = 32'h10;
   localparam int unsigned OFF_ACCEL_Y       = 32'h14;
   localparam int unsigned OFF_YAW           = 32'h18;
   localparam int unsigned OFF_START_POINT   = 32'h1C;
   localparam int unsigned OFF_END_POINT     = 32'h20;
   localparam int unsigned OFF_NEXT_DIRC     = 32'h24;
   localparam int unsigned OFF_NEXT_DIRC_VLD = 32'h28;
   localparam int unsigned OFF_RESULT_CNT    = 32'h2C;

   localparam int unsigned CTRL_START        = 0;
   localparam int unsigned CTRL_IRQ_EN       = 1;

   localparam int unsigned STATUS_DONE       = 0;
   localparam int unsigned STATUS_IDLE       = 1;
   localparam int unsigned STATUS_BUSY       = 2;
   localparam int unsigned STATUS_START_ERR  = 3;
   localparam int unsigned STATUS_LOCK_ERR   = 4;

   typedef enum logic [1:0] {
      CS_IDLE = 2'd0,
      CS_ARM  = 2'd1,
      CS_WAIT = 2'd2
   } ctrl_state_e;

   localparam logic [1:0] ST_IDLE = CS_IDLE;
   localparam logic [1:0] ST_ARM  = CS_ARM;
   localparam logic [1:0] ST_WAIT = CS_WAIT;

   function automatic int unsigned word_idx(input int unsigned byte_off);
      return byte_off >> 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/accel_ahb_regs_if.sv
// ---------------------------------------------------------------------------
// accel_ahb_regs_if : AHB-Lite slave-port signal bundle.       Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface accel_ahb_regs_if #(
   parameter int DATA_W = 32
);
   logic              HSEL;
   logic [31:0]       HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [DATA_W-1:0] HWDATA;
   logic              HREADY;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADYOUT;
   logic [1:0]        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

`default_nettype wire

// File: rtl/accel_ahb_regs_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// accel_ctrl_fsm : ap_ctrl_hs start/ready/done handshake sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accel_ctrl_fsm
   import accel_regs_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start_req,
   input  logic ap_ready,
   input  logic ap_done,
   output logic ap_start,
   output logic busy,
   output logic done_set,
   output logic start_err
);

   logic [1:0] state_q, state_d;
   logic       ap_start_q, ap_start_d;

   always_comb begin
      state_d    = state_q;
      ap_start_d = ap_start_q;
      done_set   = 1'b0;
      start_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               state_d    = ST_ARM;
               ap_start_d = 1'b1;
            end
         end
         ST_ARM: begin
            ap_start_d = 1'b1;
            start_err  = start_req;
            if (ap_ready) begin
               ap_start_d = 1'b0;
               // A kernel that finishes in the accepting cycle skips WAIT.
               if (ap_done) begin
                  state_d  = ST_IDLE;
                  done_set = 1'b1;
               end else begin
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            start_err = start_req;
            if (ap_done) begin
               state_d  = ST_IDLE;
               done_set = 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            ap_start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ap_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ap_start_q <= ap_start_d;
      end
   end

   assign ap_start = ap_start_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/accel_ahb_regs.sv
// ---------------------------------------------------------------------------
// accel_ahb_regs : zero-wait AHB-Lite register bank fronting the HLS
//                  parking-guide accelerator.                  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accel_ahb_regs
   import accel_regs_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
)(
   input  logic              HCLK,
   input  logic              HRESETn,
   accel_ahb_regs_if.slave   bus,
   output logic              ap_start,
   input  logic              ap_done,
   input  logic              ap_idle,
   input  logic              ap_ready,
   output logic [DATA_W-1:0] accel_x,
   output logic [DATA_W-1:0] accel_y,
   output logic [DATA_W-1:0] yaw,
   output logic [DATA_W-1:0] start_point,
   output logic [DATA_W-1:0] end_point,
   input  logic [DATA_W-1:0] next_dirc,
   input  logic              next_dirc_ap_vld,
   output logic              irq
);

   localparam int IW      = ADDR_W - 2;
   localparam int NUM_OPS = 5;
   localparam int unsigned OP_OFF [NUM_OPS] = '{OFF_ACCEL_X, OFF_ACCEL_Y, OFF_YAW,
                                                OFF_START_POINT, OFF_END_POINT};

   localparam logic [IW-1:0] IDX_CTRL   = IW'(word_idx(OFF_CTRL));
   localparam logic [IW-1:0] IDX_STATUS = IW'(word_idx(OFF_STATUS));
   localparam logic [IW-1:0] IDX_NDIRC  = IW'(word_idx(OFF_NEXT_DIRC));
   localparam logic [IW-1:0] IDX_NVLD   = IW'(word_idx(OFF_NEXT_DIRC_VLD));
   localparam logic [IW-1:0] IDX_CNT    = IW'(word_idx(OFF_RESULT_CNT));

   // address-phase capture
   logic [IW-1:0]     addr_idx_q, addr_idx_d;
   logic              write_q, write_d;
   logic              valid_q, valid_d;
   logic              addr_valid;

   // register file
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d;
   logic              start_err_q, start_err_d;
   logic              lock_err_q, lock_err_d;
   logic [DATA_W-1:0] op_q [NUM_OPS];
   logic [DATA_W-1:0] op_d [NUM_OPS];
   logic [DATA_W-1:0] next_dirc_q, next_dirc_d;
   logic              nvld_q, nvld_d;
   logic [CNT_W-1:0]  result_cnt_q, result_cnt_d;
   logic              irq_q, irq_d;

   logic              wr, rd;
   logic              wr_ctrl, wr_status, wr_nvld;
   logic              op_wr_any;
   logic              start_req, busy, done_set, start_err;
   logic [DATA_W-1:0] rdata;
   logic              unused_bus;

   assign unused_bus = ^{bus.HADDR[31:ADDR_W], bus.HADDR[1:0], bus.HSIZE, bus.HTRANS[0]};

   always_comb begin
      addr_valid = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
      addr_idx_d = addr_valid ? bus.HADDR[ADDR_W-1:2] : addr_idx_q;
      write_d    = addr_valid & bus.HWRITE;
      valid_d    = addr_valid;
   end

   assign wr        = valid_q & write_q;
   assign rd        = valid_q & ~write_q;
   assign wr_ctrl   = wr && (addr_idx_q == IDX_CTRL);
   assign wr_status = wr && (addr_idx_q == IDX_STATUS);
   assign wr_nvld   = wr && (addr_idx_q == IDX_NVLD);
   assign start_req = wr_ctrl & bus.HWDATA[CTRL_START];

   accel_ctrl_fsm u_ctrl_fsm (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .start_req (start_req),
      .ap_ready  (ap_ready),
      .ap_done   (ap_done),
      .ap_start  (ap_start),
      .busy      (busy),
      .done_set  (done_set),
      .start_err (start_err)
   );

   // Operands are frozen while a run is in flight so the kernel sees stable inputs.
   always_comb begin
      op_wr_any = 1'b0;
      for (int i = 0; i < NUM_OPS; i++) begin
         op_d[i] = op_q[i];
         if (wr && (addr_idx_q == IW'(word_idx(OP_OFF[i])))) begin
            op_wr_any = 1'b1;
            if (!busy) begin
               op_d[i] = bus.HWDATA;
            end
         end
      end
   end

   // Sticky bits: a hardware set in the same cycle as a W1C wins.
   always_comb begin
      irq_en_d     = wr_ctrl ? bus.HWDATA[CTRL_IRQ_EN] : irq_en_q;
      done_d       = done_set |
                     (done_q & ~(wr_status & bus.HWDATA[STATUS_DONE]));
      start_err_d  = start_err |
                     (start_err_q & ~(wr_status & bus.HWDATA[STATUS_START_ERR]));
      lock_err_d   = (op_wr_any & busy) |
                     (lock_err_q & ~(wr_status & bus.HWDATA[STATUS_LOCK_ERR]));
      next_dirc_d  = next_dirc_ap_vld ? next_dirc : next_dirc_q;
      nvld_d       = next_dirc_ap_vld | (nvld_q & ~(wr_nvld & bus.HWDATA[0]));
      result_cnt_d = result_cnt_q + CNT_W'(next_dirc_ap_vld);
      irq_d        = irq_en_q & done_q;
   end

   always_comb begin
      rdata = '0;
      case (addr_idx_q)
         IDX_CTRL: begin
            rdata[CTRL_START]  = busy;
            rdata[CTRL_IRQ_EN] = irq_en_q;
         end
         IDX_STATUS: begin
            rdata[STATUS_DONE]      = done_q;
            rdata[STATUS_IDLE]      = ap_idle;
            rdata[STATUS_BUSY]      = busy;
            rdata[STATUS_START_ERR] = start_err_q;
            rdata[STATUS_LOCK_ERR]  = lock_err_q;
         end
         IDX_NDIRC: rdata = next_dirc_q;
         IDX_NVLD:  rdata[0] = nvld_q;
         IDX_CNT:   rdata = DATA_W'(result_cnt_q);
         default: begin
            for (int i = 0; i < NUM_OPS; i++) begin
               if (addr_idx_q == IW'(word_idx(OP_OFF[i]))) begin
                  rdata = op_q[i];
               end
            end
         end
      endcase
   end

   assign bus.HRDATA    = rd ? rdata : '0;
   assign bus.HREADYOUT = 1'b1;
   assign bus.HRESP     = 2'b00;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_idx_q   <= '0;
         write_q      <= 1'b0;
         valid_q      <= 1'b0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         start_err_q  <= 1'b0;
         lock_err_q   <= 1'b0;
         for (int i = 0; i < NUM_OPS; i++) begin
            op_q[i] <= '0;
         end
         next_dirc_q  <= '0;
         nvld_q       <= 1'b0;
         result_cnt_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         addr_idx_q   <= addr_idx_d;
         write_q      <= write_d;
         valid_q      <= valid_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         start_err_q  <= start_err_d;
         lock_err_q   <= lock_err_d;
         for (int i = 0; i < NUM_OPS; i++) begin
            op_q[i] <= op_d[i];
         end
         next_dirc_q  <= next_dirc_d;
         nvld_q       <= nvld_d;
         result_cnt_q <= result_cnt_d;
         irq_q        <= irq_d;
      end
   end

   assign accel_x     = op_q[0];
   assign accel_y     = op_q[1];
   assign yaw         = op_q[2];
   assign start_point = op_q[3];
   assign end_point   = op_q[4];
   assign irq         = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_ahb_regs.sv
// ---------------------------------------------------------------------------
// tb_accel_ahb_regs : directed + randomized bench for accel_ahb_regs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_accel_ahb_regs;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        ap_start, ap_done, ap_idle, ap_ready, irq;
   logic [31:0] accel_x, accel_y, yaw, start_point, end_point;
   logic [31:0] next_dirc;
   logic        next_dirc_ap_vld;

   accel_ahb_regs_if #(.DATA_W(32)) ahb ();

   accel_ahb_regs #(.ADDR_W(6), .DATA_W(32), .CNT_W(16)) dut (
      .HCLK             (HCLK),
      .HRESETn          (HRESETn),
      .bus              (ahb),
      .ap_start         (ap_start),
      .ap_done          (ap_done),
      .ap_idle          (ap_idle),
      .ap_ready         (ap_ready),
      .accel_x          (accel_x),
      .accel_y          (accel_y),
      .yaw              (yaw),
      .start_point      (start_point),
      .end_point        (end_point),
      .next_dirc        (next_dirc),
      .next_dirc_ap_vld (next_dirc_ap_vld),
      .irq              (irq)
   );

   always #5 HCLK = ~HCLK;

   // Reference model of the programmer-visible state
   bit          m_irq_en, m_done, m_serr, m_lock, m_busy, m_vld;
   logic [31:0] m_ops [5];
   logic [31:0] m_nd;
   int unsigned m_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [31:0] mapped [11] = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C,
                                32'h20, 32'h24, 32'h28, 32'h2C, 32'h3C};
   logic [31:0] wr_addrs [10] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
                                  32'h24, 32'h2C, 32'h08, 32'h0C, 32'h30};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_irq_en = 0; m_done = 0; m_serr = 0; m_lock = 0; m_busy = 0; m_vld = 0;
      for (int i = 0; i < 5; i++) m_ops[i] = '0;
      m_nd  = '0;
      m_cnt = 0;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
      case (a[5:0])
         6'h00: begin
            m_irq_en = d[1];
            if (d[0]) begin
               if (m_busy) m_serr = 1;
               else        m_busy = 1;
            end
         end
         6'h04: begin
            if (d[0]) m_done = 0;
            if (d[3]) m_serr = 0;
            if (d[4]) m_lock = 0;
         end
         6'h10, 6'h14, 6'h18, 6'h1C, 6'h20: begin
            if (m_busy) m_lock = 1;
            else        m_ops[(a[5:0] - 6'h10) >> 2] = d;
         end
         6'h28: if (d[0]) m_vld = 0;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      case (a[5:0])
         6'h00: return {30'b0, m_irq_en, m_busy};
         6'h04: return {27'b0, m_lock, m_serr, m_busy, ap_idle, m_done};
         6'h10, 6'h14, 6'h18, 6'h1C, 6'h20: return m_ops[(a[5:0] - 6'h10) >> 2];
         6'h24: return m_nd;
         6'h28: return {31'b0, m_vld};
         6'h2C: return m_cnt % 32'h10000;
         default: return 32'h0;
      endcase
   endfunction

   task automatic bus_idle();
      ahb.HSEL = 0; ahb.HTRANS = 2'b00; ahb.HWRITE = 0;
   endtask

   task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge HCLK); #1;
      ahb.HSEL = 1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1; ahb.HADDR = a;
      @(posedge HCLK); #1;
      bus_idle();
      ahb.HWDATA = d;
      model_write(a, d);
   endtask

   task automatic ahb_read(input logic [31:0] a);
      @(posedge HCLK); #1;
      ahb.HSEL = 1; ahb.HTRANS = 2'b10; ahb.HWRITE = 0; ahb.HADDR = a;
      @(posedge HCLK); #1;
      bus_idle();
      @(negedge HCLK);
      check($sformatf("rd_%02h", a[7:0]), ahb.HRDATA, exp_read(a));
      check("ready_okay", {29'b0, ahb.HRESP, ahb.HREADYOUT}, 32'h1);
   endtask

   task automatic pulse_vld(input logic [31:0] d);
      @(negedge HCLK);
      next_dirc = d; next_dirc_ap_vld = 1;
      @(negedge HCLK);
      next_dirc_ap_vld = 0;
      m_nd = d; m_vld = 1; m_cnt++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v, a;
      int unsigned n;
      bit seen;

      HRESETn = 0;
      ahb.HSEL = 0; ahb.HTRANS = 0; ahb.HWRITE = 0; ahb.HSIZE = 3'b010;
      ahb.HADDR = 0; ahb.HWDATA = 0; ahb.HREADY = 1;
      ap_done = 0; ap_idle = 1; ap_ready = 0; next_dirc = 0; next_dirc_ap_vld = 0;
      model_reset();
      #12;
      check("rst_ap_start", {31'b0, ap_start}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_hrdata", ahb.HRDATA, 32'h0);
      check("rst_ready_okay", {29'b0, ahb.HRESP, ahb.HREADYOUT}, 32'h1);
      @(negedge HCLK);
      HRESETn = 1;

      foreach (mapped[i]) ahb_read(mapped[i]);

      // randomized operand/unmapped/RO traffic while idle
      for (int i = 0; i < 16; i++) begin
         a = wr_addrs[$urandom_range(0, 9)];
         ahb_write(a, $urandom);
         ahb_read(mapped[$urandom_range(0, 10)]);
      end
      @(negedge HCLK);
      check("accel_x_out", accel_x, m_ops[0]);
      check("accel_y_out", accel_y, m_ops[1]);
      check("yaw_out", yaw, m_ops[2]);
      check("start_point_out", start_point, m_ops[3]);
      check("end_point_out", end_point, m_ops[4]);

      // back-to-back write then read of the same address
      v = $urandom;
      @(posedge HCLK); #1;
      ahb.HSEL = 1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1; ahb.HADDR = 32'h1C;
      @(posedge HCLK); #1;
      ahb.HWDATA = v; ahb.HWRITE = 0;
      model_write(32'h1C, v);
      @(posedge HCLK); #1;
      bus_idle();
      @(negedge HCLK);
      check("b2b_wr_rd", ahb.HRDATA, v);

      // run 1: exact handshake timing
      ahb_write(32'h10, 32'h0000_1234);
      ahb_write(32'h00, 32'h1);
      @(negedge HCLK);
      check("ap_start_before", {31'b0, ap_start}, 32'h0);
      check("accel_x_before_start", accel_x, 32'h1234);
      @(negedge HCLK);
      check("ap_start_rise", {31'b0, ap_start}, 32'h1);
      ap_idle = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK);
         check("ap_start_hold", {31'b0, ap_start}, 32'h1);
      end
      ap_ready = 1;
      @(negedge HCLK);
      ap_ready = 0;
      check("ap_start_drop", {31'b0, ap_start}, 32'h0);
      repeat (9) @(negedge HCLK);
      ap_done = 1; ap_idle = 1;
      @(negedge HCLK);
      ap_done = 0;
      m_done = 1; m_busy = 0;
      ahb_read(32'h04);
      ahb_read(32'h00);
      check("irq_disabled", {31'b0, irq}, 32'h0);

      // run 2: start/lock errors in WAIT, then done colliding with W1C
      ahb_write(32'h04, 32'h1);
      ahb_write(32'h00, 32'h1);
      @(negedge HCLK);
      @(negedge HCLK);
      check("ap_start_run2", {31'b0, ap_start}, 32'h1);
      ap_idle = 0; ap_ready = 1;
      @(negedge HCLK);
      ap_ready = 0;
      ahb_write(32'h00, 32'h1);
      ahb_write(32'h18, 32'h5);
      @(negedge HCLK);
      @(negedge HCLK);
      check("no_restart", {31'b0, ap_start}, 32'h0);
      check("yaw_locked", yaw, m_ops[2]);
      ahb_read(32'h04);
      ahb_write(32'h04, 32'h18);
      ahb_read(32'h04);
      ahb_read(32'h18);
      ahb_write(32'h00, 32'h2);
      @(negedge HCLK);
      @(negedge HCLK);
      check("irq_en_no_done", {31'b0, irq}, 32'h0);
      @(posedge HCLK); #1;
      ahb.HSEL = 1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1; ahb.HADDR = 32'h04;
      @(posedge HCLK); #1;
      bus_idle();
      ahb.HWDATA = 32'h1; ap_done = 1; ap_idle = 1;
      @(posedge HCLK); #1;
      ap_done = 0;
      model_write(32'h04, 32'h1);
      m_done = 1; m_busy = 0;
      check("irq_lag", {31'b0, irq}, 32'h0);
      @(posedge HCLK); #1;
      check("irq_set", {31'b0, irq}, 32'h1);
      ahb_read(32'h04);
      ahb_read(32'h00);

      // result capture and counter wrap
      pulse_vld(32'hA5);
      ahb_read(32'h24);
      ahb_read(32'h28);
      ahb_read(32'h2C);
      for (int i = 0; i < 3; i++) begin
         pulse_vld($urandom);
         ahb_read(32'h24);
         ahb_read(32'h2C);
      end
      ahb_write(32'h28, 32'h1);
      ahb_read(32'h28);
      n = 32'hFFFF - m_cnt;
      @(negedge HCLK);
      next_dirc_ap_vld = 1;
      for (int unsigned i = 0; i < n; i++) begin
         next_dirc = $urandom;
         m_nd = next_dirc;
         @(negedge HCLK);
      end
      next_dirc_ap_vld = 0;
      m_cnt += n; m_vld = 1;
      ahb_read(32'h2C);
      pulse_vld(32'h5A);
      ahb_read(32'h2C);
      ahb_read(32'h24);
      ahb_read(32'h28);

      ahb_write(32'h04, 32'h1);
      ahb_read(32'h04);
      check("irq_cleared", {31'b0, irq}, {31'b0, m_irq_en & m_done});

      // reset while ARM
      ahb_write(32'h00, 32'h1);
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge HCLK);
         seen = ap_start;
      end
      check("arm_reached", {31'b0, seen}, 32'h1);
      #2;
      HRESETn = 0;
      #1;
      check("async_ap_start", {31'b0, ap_start}, 32'h0);
      check("async_irq", {31'b0, irq}, 32'h0);
      model_reset();
      @(negedge HCLK);
      HRESETn = 1;
      ap_idle = 1;
      check("post_rst_accel_x", accel_x, 32'h0);
      ahb_read(32'h00);
      ahb_read(32'h04);
      ahb_read(32'h10);
      ahb_read(32'h2C);

      ahb_write(32'h3C, $urandom);
      ahb_read(32'h3C);
      foreach (mapped[i]) ahb_read(mapped[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
